// File: rtl/dpwm_pkg.sv
// ============================================================================
// dpwm_pkg : shared state encoding and limits for the DPWM front-end blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package dpwm_pkg;

    localparam int W_DEFAULT = 12;
    localparam int FS_MIN    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } dpwm_state_e;

endpackage

`default_nettype wire

// File: rtl/dpwm_period_timer.sv
// ============================================================================
// dpwm_period_timer : period counter with boundary flag and period_start strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module dpwm_period_timer
    import dpwm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         active_i,
    input  logic         active_next_i,
    input  logic [W-1:0] fs_i,
    output logic         boundary_o,
    output logic         period_start_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ps_q, ps_d;
    logic         w_boundary;

    assign w_boundary = active_i && (cnt_q == (fs_i - W'(1)));

    // A fresh period begins on entry to an active state or after a boundary
    // that keeps the timer running.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        ps_d  = 1'b0;
        if (!active_next_i) begin
            cnt_d = '0;
        end else if (!active_i || w_boundary) begin
            cnt_d = '0;
            ps_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ps_q  <= ps_d;
        end
    end

    assign boundary_o     = w_boundary;
    assign period_start_o = ps_q;

endmodule

`default_nettype wire

// File: rtl/dpwm_softstart_ctrl.sv
// ============================================================================
// dpwm_softstart_ctrl : shadow registers, soft-start ramp and fault/stop
// sequencing in front of the DPWM core; all updates land on period boundaries.
// Rev 1.0
// ============================================================================
`default_nettype none

module dpwm_softstart_ctrl
    import dpwm_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              hf_clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              fault,
    input  logic              fault_clr,
    input  logic [W-1:0]      target_dc,
    input  logic [W-1:0]      fs_cfg,
    input  logic [W-1:0]      dt1_cfg,
    input  logic [W-1:0]      dt2_cfg,
    input  logic [STEP_W-1:0] ramp_step,
    input  logic [DIV_W-1:0]  ramp_div,
    output logic [W-1:0]      duty_cycle,
    output logic [W-1:0]      fs,
    output logic [W-1:0]      deadtime1,
    output logic [W-1:0]      deadtime2,
    output logic              enable,
    output logic              period_start,
    output logic [1:0]        state,
    output logic              ramp_done
);

    dpwm_state_e      state_q, state_d;
    logic [W-1:0]     duty_q, duty_d;
    logic [W-1:0]     fs_q, fs_d;
    logic [W-1:0]     dt1_q, dt1_d;
    logic [W-1:0]     dt2_q, dt2_d;
    logic             en_q, en_d;
    logic             rdone_q, rdone_d;
    logic             stop_pend_q, stop_pend_d;
    logic [DIV_W-1:0] dcnt_q, dcnt_d;

    logic             w_boundary;
    logic             w_active, w_active_next;
    logic [W:0]       w_sum;
    logic [W-1:0]     w_stepped;
    logic             w_fs_ok;

    assign w_active      = (state_q == ST_RAMP) || (state_q == ST_RUN);
    assign w_active_next = (state_d == ST_RAMP) || (state_d == ST_RUN);
    assign w_fs_ok       = (fs_cfg >= W'(FS_MIN));

    // One extra bit keeps the step from wrapping before saturation at target.
    assign w_sum     = {1'b0, duty_q} + (W+1)'(ramp_step);
    assign w_stepped = (w_sum >= {1'b0, target_dc}) ? target_dc : w_sum[W-1:0];

    dpwm_period_timer #(.W(W)) u_timer (
        .clk_i          (hf_clock),
        .rst_ni         (reset),
        .active_i       (w_active),
        .active_next_i  (w_active_next),
        .fs_i           (fs_q),
        .boundary_o     (w_boundary),
        .period_start_o (period_start)
    );

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        fs_d        = fs_q;
        dt1_d       = dt1_q;
        dt2_d       = dt2_q;
        en_d        = en_q;
        rdone_d     = 1'b0;
        stop_pend_d = stop_pend_q;
        dcnt_d      = dcnt_q;

        if (fault && (state_q != ST_FAULT)) begin
            state_d     = ST_FAULT;
            en_d        = 1'b0;
            duty_d      = '0;
            stop_pend_d = 1'b0;
            dcnt_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop && w_fs_ok) begin
                        state_d     = ST_RAMP;
                        fs_d        = fs_cfg;
                        dt1_d       = dt1_cfg;
                        dt2_d       = dt2_cfg;
                        en_d        = 1'b1;
                        duty_d      = '0;
                        dcnt_d      = '0;
                        stop_pend_d = 1'b0;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    if (stop) begin
                        stop_pend_d = 1'b1;
                    end
                    if (w_boundary) begin
                        if (stop || stop_pend_q) begin
                            state_d     = ST_IDLE;
                            en_d        = 1'b0;
                            duty_d      = '0;
                            stop_pend_d = 1'b0;
                            dcnt_d      = '0;
                        end else if (state_q == ST_RAMP) begin
                            if (target_dc < duty_q) begin
                                duty_d  = target_dc;
                                state_d = ST_RUN;
                                rdone_d = 1'b1;
                                dcnt_d  = '0;
                            end else if (dcnt_q == ramp_div) begin
                                dcnt_d = '0;
                                duty_d = w_stepped;
                                if (w_stepped == target_dc) begin
                                    state_d = ST_RUN;
                                    rdone_d = 1'b1;
                                end
                            end else begin
                                dcnt_d = dcnt_q + DIV_W'(1);
                            end
                        end else begin
                            duty_d = target_dc;
                            dt1_d  = dt1_cfg;
                            dt2_d  = dt2_cfg;
                            if (w_fs_ok) begin
                                fs_d = fs_cfg;
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && !fault) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge hf_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            duty_q      <= '0;
            fs_q        <= '0;
            dt1_q       <= '0;
            dt2_q       <= '0;
            en_q        <= 1'b0;
            rdone_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            dcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            fs_q        <= fs_d;
            dt1_q       <= dt1_d;
            dt2_q       <= dt2_d;
            en_q        <= en_d;
            rdone_q     <= rdone_d;
            stop_pend_q <= stop_pend_d;
            dcnt_q      <= dcnt_d;
        end
    end

    assign duty_cycle = duty_q;
    assign fs         = fs_q;
    assign deadtime1  = dt1_q;
    assign deadtime2  = dt2_q;
    assign enable     = en_q;
    assign state      = state_q;
    assign ramp_done  = rdone_q;

endmodule

`default_nettype wire

// File: tb/tb_dpwm_softstart_ctrl.sv
// ============================================================================
// tb_dpwm_softstart_ctrl : scoreboard bench; expectations are queued with a
// due cycle when stimulus is driven and compared on the falling edge.
// ============================================================================
`default_nettype none

module tb_dpwm_softstart_ctrl;

    localparam int W      = 12;
    localparam int STEP_W = 8;
    localparam int DIV_W  = 8;

    localparam int F_DUTY  = 0;
    localparam int F_FS    = 1;
    localparam int F_DT1   = 2;
    localparam int F_DT2   = 3;
    localparam int F_EN    = 4;
    localparam int F_PS    = 5;
    localparam int F_STATE = 6;
    localparam int F_RDONE = 7;

    logic              hf_clock = 1'b0;
    logic              reset;
    logic              start, stop, fault, fault_clr;
    logic [W-1:0]      target_dc, fs_cfg, dt1_cfg, dt2_cfg;
    logic [STEP_W-1:0] ramp_step;
    logic [DIV_W-1:0]  ramp_div;
    logic [W-1:0]      duty_cycle, fs, deadtime1, deadtime2;
    logic              enable, period_start, ramp_done;
    logic [1:0]        state;

    dpwm_softstart_ctrl #(.W(W), .STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
        .hf_clock     (hf_clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .target_dc    (target_dc),
        .fs_cfg       (fs_cfg),
        .dt1_cfg      (dt1_cfg),
        .dt2_cfg      (dt2_cfg),
        .ramp_step    (ramp_step),
        .ramp_div     (ramp_div),
        .duty_cycle   (duty_cycle),
        .fs           (fs),
        .deadtime1    (deadtime1),
        .deadtime2    (deadtime2),
        .enable       (enable),
        .period_start (period_start),
        .state        (state),
        .ramp_done    (ramp_done)
    );

    always #5 hf_clock = ~hf_clock;

    typedef struct {
        int          due;
        int          fld;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_err     = 0;
    int   rd_pulses = 0;
    int   s;

    always @(posedge hf_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [31:0] field(input int f);
        logic [31:0] v;
        case (f)
            F_DUTY:  v = 32'(duty_cycle);
            F_FS:    v = 32'(fs);
            F_DT1:   v = 32'(deadtime1);
            F_DT2:   v = 32'(deadtime2);
            F_EN:    v = 32'(enable);
            F_PS:    v = 32'(period_start);
            F_STATE: v = 32'(state);
            default: v = 32'(ramp_done);
        endcase
        return v;
    endfunction

    task automatic exp_at(input string tag, input int fld, input int val, input int dly);
        exp_t e;
        e.due = cyc + dly;
        e.fld = fld;
        e.val = 32'(val);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge hf_clock);
            #1;
        end
    endtask

    task automatic tick();
        @(posedge hf_clock);
        #1;
    endtask

    always @(negedge hf_clock) begin
        if (reset === 1'b1 && ramp_done === 1'b1) rd_pulses++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, field(sb[i].fld), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        target_dc = '0; fs_cfg = '0; dt1_cfg = '0; dt2_cfg = '0;
        ramp_step = '0; ramp_div = '0;

        repeat (4) @(posedge hf_clock);
        #1;
        exp_at("rst_duty",  F_DUTY,  0, 0);
        exp_at("rst_en",    F_EN,    0, 0);
        exp_at("rst_state", F_STATE, 0, 0);
        exp_at("rst_fs",    F_FS,    0, 0);
        exp_at("rst_ps",    F_PS,    0, 0);
        exp_at("rst_rdone", F_RDONE, 0, 0);
        reset = 1'b1;
        exp_at("idle_state", F_STATE, 0, 1);
        exp_at("idle_en",    F_EN,    0, 50);
        exp_at("idle_duty",  F_DUTY,  0, 50);
        exp_at("idle_ps",    F_PS,    0, 100);
        exp_at("idle_state", F_STATE, 0, 100);
        go(cyc + 100);

        // soft-start: 10,20,..,50 on every second boundary
        fs_cfg = 12'd100; target_dc = 12'd50; ramp_step = 8'd10; ramp_div = 8'd1;
        dt1_cfg = 12'd10; dt2_cfg = 12'd12;
        start = 1'b1;
        s = cyc;
        exp_at("ss_en",      F_EN,    1, 1);
        exp_at("ss_state",   F_STATE, 1, 1);
        exp_at("ss_fs",      F_FS,    100, 1);
        exp_at("ss_dt1",     F_DT1,   10, 1);
        exp_at("ss_dt2",     F_DT2,   12, 1);
        exp_at("ss_ps0",     F_PS,    1, 1);
        exp_at("ss_ps_lo",   F_PS,    0, 2);
        exp_at("ss_ps1",     F_PS,    1, 101);
        exp_at("ss_duty_b1", F_DUTY,  0, 200);
        exp_at("ss_duty10",  F_DUTY,  10, 201);
        exp_at("ss_duty10h", F_DUTY,  10, 400);
        exp_at("ss_duty20",  F_DUTY,  20, 401);
        exp_at("ss_duty30",  F_DUTY,  30, 601);
        exp_at("ss_duty40",  F_DUTY,  40, 801);
        exp_at("ss_duty40h", F_DUTY,  40, 1000);
        exp_at("ss_rd_lo",   F_RDONE, 0, 1000);
        exp_at("ss_st_ramp", F_STATE, 1, 1000);
        exp_at("ss_duty50",  F_DUTY,  50, 1001);
        exp_at("ss_rd",      F_RDONE, 1, 1001);
        exp_at("ss_st_run",  F_STATE, 2, 1001);
        exp_at("ss_rd_end",  F_RDONE, 0, 1002);
        tick();
        start = 1'b0;

        // mid-period config change lands on the next boundary
        go(s + 1030);
        target_dc = 12'd30; dt1_cfg = 12'd15; fs_cfg = 12'd1;
        exp_at("run_duty_old", F_DUTY, 50, 70);
        exp_at("run_dt1_old",  F_DT1,  10, 70);
        exp_at("run_duty_new", F_DUTY, 30, 71);
        exp_at("run_dt1_new",  F_DT1,  15, 71);
        exp_at("run_fs_keep",  F_FS,   100, 71);

        // graceful stop at cnt=40
        go(s + 1141);
        stop = 1'b1;
        exp_at("stop_en_hold", F_EN,    1, 59);
        exp_at("stop_st_hold", F_STATE, 2, 59);
        exp_at("stop_en",      F_EN,    0, 60);
        exp_at("stop_duty",    F_DUTY,  0, 60);
        exp_at("stop_state",   F_STATE, 0, 60);
        exp_at("stop_ps",      F_PS,    0, 60);
        tick();
        stop = 1'b0;
        go(s + 1210);

        // fault during ramp at cnt=17
        fs_cfg = 12'd100; target_dc = 12'd50;
        start = 1'b1;
        s = cyc;
        exp_at("flt_ramp", F_STATE, 1, 1);
        tick();
        start = 1'b0;
        go(s + 18);
        fault = 1'b1;
        exp_at("flt_pre_en", F_EN,    1, 0);
        exp_at("flt_state",  F_STATE, 3, 1);
        exp_at("flt_en",     F_EN,    0, 1);
        exp_at("flt_duty",   F_DUTY,  0, 1);
        go(s + 25);
        fault_clr = 1'b1;
        exp_at("flt_clr_blk", F_STATE, 3, 1);
        exp_at("flt_clr_blk2", F_STATE, 3, 3);
        tick();
        fault_clr = 1'b0;
        go(s + 30);
        fault = 1'b0;
        exp_at("flt_no_clr", F_STATE, 3, 2);
        go(s + 35);
        fault_clr = 1'b1;
        exp_at("flt_cleared", F_STATE, 0, 1);
        tick();
        fault_clr = 1'b0;
        go(s + 40);
        fs_cfg = 12'd1;
        start = 1'b1;
        exp_at("fs1_state", F_STATE, 0, 1);
        exp_at("fs1_en",    F_EN,    0, 1);
        exp_at("fs1_ps",    F_PS,    0, 1);
        tick();
        start = 1'b0;
        go(s + 45);
        fs_cfg = 12'd100;
        start = 1'b1; stop = 1'b1;
        exp_at("ss_stop_win", F_STATE, 0, 1);
        tick();
        start = 1'b0; stop = 1'b0;

        // maximum period load, then stop+fault together
        go(s + 50);
        fs_cfg = 12'd4095; target_dc = 12'd4095; ramp_step = 8'd255; ramp_div = 8'd0;
        start = 1'b1;
        exp_at("fsmax_fs",    F_FS,    4095, 1);
        exp_at("fsmax_state", F_STATE, 1, 1);
        exp_at("fsmax_en",    F_EN,    1, 1);
        tick();
        start = 1'b0;
        go(s + 70);
        stop = 1'b1; fault = 1'b1;
        exp_at("sf_state", F_STATE, 3, 1);
        exp_at("sf_en",    F_EN,    0, 1);
        tick();
        stop = 1'b0; fault = 1'b0;
        go(s + 75);
        fault_clr = 1'b1;
        exp_at("sf_cleared", F_STATE, 0, 1);
        tick();
        fault_clr = 1'b0;

        // saturation: 255 per period up to exactly 4095
        go(s + 80);
        fs_cfg = 12'd20;
        start = 1'b1;
        s = cyc;
        exp_at("sat_fs",     F_FS,    20, 1);
        exp_at("sat_d1",     F_DUTY,  255, 21);
        exp_at("sat_d2",     F_DUTY,  510, 41);
        exp_at("sat_d16",    F_DUTY,  4080, 321);
        exp_at("sat_d16h",   F_DUTY,  4080, 340);
        exp_at("sat_st_rmp", F_STATE, 1, 340);
        exp_at("sat_d17",    F_DUTY,  4095, 341);
        exp_at("sat_rd",     F_RDONE, 1, 341);
        exp_at("sat_st_run", F_STATE, 2, 341);
        exp_at("sat_hold",   F_DUTY,  4095, 355);
        tick();
        start = 1'b0;

        go(s + 360);
        check("rd_pulses", 32'(rd_pulses), 32'd2);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dpwm_softstart_ctrl.md
Name: dpwm_softstart_ctrl

Overview:
Sequencer and configuration front-end for the 12-bit DPWM core. It holds the shadow registers for duty cycle, switching period and both deadtimes. It applies a soft-start duty ramp and drives the core's enable. All updates land only on PWM period boundaries, so the core never sees a mid-period change. Fault handling and stop/start sequencing also live here, between the control loop / register interface and DPWM_impl.

Parameters:
W, 12, width of duty/fs/deadtime words (matches the DPWM core)
STEP_W, 8, width of ramp step increment
DIV_W, 8, width of ramp divider (periods per step minus one)

Ports:
hf_clock  in  1  DPWM high-frequency clock; same clock as the core
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: begin soft-start
stop  in  1  single-cycle pulse: graceful shutdown
fault  in  1  level; overcurrent/overvoltage trip
fault_clr  in  1  single-cycle pulse: acknowledge latched fault
target_dc  in  W  requested steady-state duty count
fs_cfg  in  W  requested period in hf_clock cycles
dt1_cfg  in  W  requested deadtime 1
dt2_cfg  in  W  requested deadtime 2
ramp_step  in  STEP_W  duty increment per ramp step
ramp_div  in  DIV_W  ramp step occurs every ramp_div+1 periods
duty_cycle  out  W  to core duty_cycle
fs  out  W  to core fs
deadtime1  out  W  to core deadtime1
deadtime2  out  W  to core deadtime2
enable  out  1  to core enable
period_start  out  1  one-cycle strobe on the first cycle of each period
state  out  2  IDLE=0, RAMP=1, RUN=2, FAULT=3
ramp_done  out  1  one-cycle pulse on RAMP->RUN

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0; state=IDLE; period counter cnt=0; divider counter dcnt=0.
- Period counter:
  - cnt counts 0..fs-1 while state is RAMP or RUN; held at 0 otherwise.
  - boundary = (cnt==fs-1). On a boundary, cnt goes to 0 and period_start=1 in the next cycle. The first period after entering RAMP also asserts period_start.
- IDLE:
  - enable=0, duty_cycle=0.
  - start & !fault & !stop & fs_cfg>=2 → RAMP. On that clock, fs/deadtime1/deadtime2 load from the *_cfg inputs and enable=1.
  - start with fs_cfg<2 is ignored.
- RAMP:
  - On each boundary, dcnt increments. When dcnt==ramp_div, dcnt clears and duty_cycle <= min(duty_cycle+ramp_step, target_dc), computed W+1 bits wide with saturation at target_dc.
  - If target_dc <= the duty value just loaded → RUN and pulse ramp_done.
  - If target_dc is below the current duty_cycle at any boundary, clamp duty_cycle to target_dc → RUN.
  - fs/deadtimes are frozen during RAMP.
- RUN:
  - on every boundary, duty_cycle<=target_dc, fs<=fs_cfg, deadtime1<=dt1_cfg, deadtime2<=dt2_cfg. No ramp on step changes.
  - fs_cfg<2 at a boundary: fs keeps its old value.
- stop in RAMP/RUN:
  - latched as stop_pend. At the next boundary: enable=0, duty_cycle=0, cnt=0 → IDLE. The current period always completes.
  - start while stop_pend is ignored. start and stop in the same cycle: stop wins.
- fault (any state except FAULT):
  - next clock: state=FAULT, enable=0, duty_cycle=0, cnt=0, stop_pend cleared. No boundary wait.
  - Fault has priority over start, stop and boundary updates in the same cycle.
- FAULT:
  - outputs held off.
  - fault_clr & !fault → IDLE. fault_clr while fault=1 is ignored. start is ignored.
- Configuration outside boundaries:
  - target_dc and *_cfg changes between boundaries have no output effect.
  - Outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package dpwm_pkg:
  - state encoding constants ST_IDLE/ST_RAMP/ST_RUN/ST_FAULT
  - default W=12
  - minimum-period constant FS_MIN=2
- One natural sub-module: dpwm_period_timer (cnt, boundary, period_start, hold/clear control), reused by later monitoring blocks.
- Ramp arithmetic and FSM stay in the top.

Test Plan:
- Reset/idle: hold reset=0 for 4 cycles, release, no start → all outputs 0, state=0 for 100 cycles.
- Soft-start:
  - stimulus: fs_cfg=100, target_dc=50, ramp_step=10, ramp_div=1, start pulse.
  - response: enable=1 next cycle; duty_cycle steps 10,20,30,40,50 at every second boundary (every 200 cycles).
  - ramp_done pulses once at the step to 50; state=RUN.
- RUN update:
  - stimulus: in RUN, change target_dc 50→30 and dt1_cfg 10→15 mid-period.
  - response: outputs unchanged until the next cnt==99 boundary, then 30/15 together.
- Graceful stop: stop pulse at cnt=40 → enable stays 1 until the boundary after cnt=99, then enable=0, duty=0, state=IDLE.
- Fault:
  - stimulus: fault=1 during RAMP at cnt=17.
  - response: the next clock shows enable=0, duty=0, state=3.
  - fault_clr while fault=1 leaves state at 3; after fault drops, fault_clr → state=0.
  - A subsequent start with fs_cfg=1 is ignored.
- Saturation:
  - stimulus: target_dc=4095, ramp_step=255, fs_cfg=4095.
  - response: duty increments without wrap and reaches exactly 4095; stop and fault asserted in the same cycle → FAULT.
